// File: rtl/instr_encoder.sv
// MIPS-32 instruction assembler: encodes mnemonic + fields into a word, queues it
// in a small FIFO and streams the queue into instruction memory at consecutive addresses.
module instr_encoder #(
   parameter int              DEPTH     = 4,
   parameter int              AW        = 32,
   parameter logic [AW-1:0]   BASE_ADDR = 32'h0000_3000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [4:0]    op_sel,
   input  logic [4:0]    rs,
   input  logic [4:0]    rt,
   input  logic [4:0]    rd,
   input  logic [4:0]    shamt,
   input  logic [25:0]   imm26,
   output logic          err_illegal,
   output logic          err_sticky,
   output logic          im_we,
   input  logic          im_ready,
   output logic [AW-1:0] im_addr,
   output logic [31:0]   im_wdata,
   output logic [15:0]   word_cnt
);

   localparam int PW = $clog2(DEPTH);

   logic [31:0]   mem [DEPTH];
   logic [PW:0]   wptr_reg, rptr_reg;
   logic [PW:0]   count;
   logic [PW-1:0] next_idx;
   logic [31:0]   head_reg;
   logic [AW-1:0] addr_reg;
   logic [15:0]   cnt_reg;
   logic          err_illegal_reg, err_sticky_reg;
   logic          full, empty, push, pop, illegal_acc;
   logic          legal;
   logic [31:0]   word;

   always_comb begin
      word  = 32'h0;
      legal = 1'b1;
      case (op_sel)
         5'd0:  word = {6'h00, rs, rt, rd, 5'd0, 6'h21};
         5'd1:  word = {6'h00, rs, rt, rd, 5'd0, 6'h20};
         5'd2:  word = {6'h00, rs, rt, rd, 5'd0, 6'h23};
         5'd3:  word = {6'h00, rs, rt, rd, 5'd0, 6'h22};
         5'd4:  word = {6'h00, rs, rt, rd, 5'd0, 6'h2A};
         5'd5:  word = {6'h00, 5'd0, rt, rd, shamt, 6'h00};
         5'd6:  word = {6'h00, 5'd0, rt, rd, shamt, 6'h02};
         5'd7:  word = {6'h00, 5'd0, rt, rd, shamt, 6'h03};
         5'd8:  word = {6'h00, rs, rt, rd, 5'd0, 6'h24};
         5'd9:  word = {6'h0D, rs, rt, imm26[15:0]};
         5'd10: word = {6'h2B, rs, rt, imm26[15:0]};
         5'd11: word = {6'h23, rs, rt, imm26[15:0]};
         5'd12: word = {6'h04, rs, rt, imm26[15:0]};
         5'd13: word = {6'h05, rs, rt, imm26[15:0]};
         5'd14: word = {6'h0F, 5'd0, rt, imm26[15:0]};
         5'd15: word = {6'h0A, rs, rt, imm26[15:0]};
         5'd16: word = {6'h02, imm26};
         default: legal = 1'b0;
      endcase
   end

   assign count       = wptr_reg - rptr_reg;
   assign empty       = (wptr_reg == rptr_reg);
   assign full        = (wptr_reg[PW] != rptr_reg[PW]) && (wptr_reg[PW-1:0] == rptr_reg[PW-1:0]);
   assign push        = in_valid && !full && legal;
   assign illegal_acc = in_valid && !full && !legal;
   assign pop         = !empty && im_ready;
   assign next_idx    = rptr_reg[PW-1:0] + PW'(1);

   always_ff @(posedge clk) begin
      if (push)
         mem[wptr_reg[PW-1:0]] <= word;
   end

   // head_reg mirrors the FIFO head so the word holds steady when the queue empties
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_reg        <= '0;
         rptr_reg        <= '0;
         head_reg        <= 32'h0;
         addr_reg        <= BASE_ADDR;
         cnt_reg         <= 16'h0;
         err_illegal_reg <= 1'b0;
         err_sticky_reg  <= 1'b0;
      end else if (clear) begin
         wptr_reg        <= '0;
         rptr_reg        <= '0;
         addr_reg        <= BASE_ADDR;
         cnt_reg         <= 16'h0;
         err_illegal_reg <= 1'b0;
         err_sticky_reg  <= 1'b0;
      end else begin
         err_illegal_reg <= illegal_acc;
         if (illegal_acc)
            err_sticky_reg <= 1'b1;
         if (push)
            wptr_reg <= wptr_reg + (PW+1)'(1);
         if (pop) begin
            rptr_reg <= rptr_reg + (PW+1)'(1);
            addr_reg <= addr_reg + AW'(4);
            if (cnt_reg != 16'hFFFF)
               cnt_reg <= cnt_reg + 16'd1;
            if (count > (PW+1)'(1))
               head_reg <= mem[next_idx];
            else if (push)
               head_reg <= word;
         end else if (empty && push) begin
            head_reg <= word;
         end
      end
   end

   assign in_ready    = !full;
   assign im_we       = !empty;
   assign im_addr     = addr_reg;
   assign im_wdata    = head_reg;
   assign word_cnt    = cnt_reg;
   assign err_illegal = err_illegal_reg;
   assign err_sticky  = err_sticky_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encoding table, FIFO full/drain, illegal ops,
// clear priority and asynchronous reset, all checked against a small queue model.
module tb_instr_encoder;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst, clear, in_valid, im_ready;
   logic [4:0]  op_sel, rs, rt, rd, shamt;
   logic [25:0] imm26;
   logic        in_ready, err_illegal, err_sticky, im_we;
   logic [31:0] im_addr, im_wdata;
   logic [15:0] word_cnt;

   always #5 clk = ~clk;

   instr_encoder #(.DEPTH(DEPTH), .AW(32), .BASE_ADDR(32'h0000_3000)) dut (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
      .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm26(imm26),
      .err_illegal(err_illegal), .err_sticky(err_sticky), .im_we(im_we),
      .im_ready(im_ready), .im_addr(im_addr), .im_wdata(im_wdata), .word_cnt(word_cnt)
   );

   typedef struct {
      logic [4:0]  op, rs, rt, rd, sh;
      logic [25:0] imm;
      logic [31:0] exp;
   } vec_t;

   vec_t        vecs [11];
   logic [31:0] q [$];
   logic [31:0] m_addr, m_last, cur_exp;
   logic [15:0] m_cnt;
   bit          m_sticky, m_pulse;
   int          tests = 0;
   int          fails = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic mreset();
      q.delete();
      m_addr   = 32'h0000_3000;
      m_last   = 32'h0;
      m_cnt    = 16'h0;
      m_sticky = 1'b0;
      m_pulse  = 1'b0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, " in_ready"}, {31'b0, in_ready}, {31'b0, q.size() < DEPTH});
      chk({tag, " im_we"}, {31'b0, im_we}, {31'b0, q.size() > 0});
      chk({tag, " im_addr"}, im_addr, m_addr);
      chk({tag, " word_cnt"}, {16'b0, word_cnt}, {16'b0, m_cnt});
      chk({tag, " err_illegal"}, {31'b0, err_illegal}, {31'b0, m_pulse});
      chk({tag, " err_sticky"}, {31'b0, err_sticky}, {31'b0, m_sticky});
      chk({tag, " im_wdata"}, im_wdata, (q.size() > 0) ? q[0] : m_last);
   endtask

   // one clock: model the accepting edge, then compare on the falling edge
   task automatic step(input string tag);
      bit room, lg, pop;
      @(posedge clk);
      if (clear) begin
         if (q.size() > 0) m_last = q[0];
         q.delete();
         m_addr   = 32'h0000_3000;
         m_cnt    = 16'h0;
         m_sticky = 1'b0;
         m_pulse  = 1'b0;
      end else begin
         room    = q.size() < DEPTH;
         lg      = op_sel < 5'd17;
         pop     = (q.size() > 0) && im_ready;
         m_pulse = in_valid && room && !lg;
         if (m_pulse) m_sticky = 1'b1;
         if (pop) begin
            m_last = q.pop_front();
            m_addr = m_addr + 32'd4;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         end
         if (in_valid && room && lg) q.push_back(cur_exp);
      end
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic req(input logic [4:0] o, input logic [4:0] s, input logic [4:0] t,
                      input logic [4:0] d, input logic [4:0] sh, input logic [25:0] im,
                      input logic [31:0] e);
      op_sel = o; rs = s; rt = t; rd = d; shamt = sh; imm26 = im;
      cur_exp  = e;
      in_valid = 1'b1;
   endtask

   initial begin
      vecs[0]  = '{5'd0,  5'd1,  5'd2,  5'd3,  5'd0,  26'h0,       32'h00221821};
      vecs[1]  = '{5'd9,  5'd0,  5'd1,  5'd0,  5'd0,  26'h1234,    32'h34011234};
      vecs[2]  = '{5'd11, 5'd29, 5'd8,  5'd0,  5'd0,  26'hFFFC,    32'h8FA8FFFC};
      vecs[3]  = '{5'd5,  5'd7,  5'd2,  5'd4,  5'd3,  26'h0,       32'h000220C0};
      vecs[4]  = '{5'd16, 5'd0,  5'd0,  5'd0,  5'd0,  26'h0000C00, 32'h08000C00};
      vecs[5]  = '{5'd1,  5'd4,  5'd5,  5'd6,  5'd7,  26'h0,       32'h00853020};
      vecs[6]  = '{5'd14, 5'd3,  5'd9,  5'd0,  5'd0,  26'hABCD,    32'h3C09ABCD};
      vecs[7]  = '{5'd7,  5'd1,  5'd2,  5'd3,  5'd31, 26'h0,       32'h00021FC3};
      vecs[8]  = '{5'd12, 5'd8,  5'd9,  5'd0,  5'd0,  26'h3FFFFFF, 32'h1109FFFF};
      vecs[9]  = '{5'd4,  5'd31, 5'd31, 5'd31, 5'd5,  26'h0,       32'h03FFF82A};
      vecs[10] = '{5'd10, 5'd2,  5'd3,  5'd0,  5'd0,  26'h0010,    32'hAC430010};

      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; im_ready = 1'b1;
      op_sel = '0; rs = '0; rt = '0; rd = '0; shamt = '0; imm26 = '0; cur_exp = '0;
      mreset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_all("reset");
      $display("[TB] reset state checked");

      foreach (vecs[i]) begin
         req(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh, vecs[i].imm, vecs[i].exp);
         step($sformatf("vec%0d accept", i));
         in_valid = 1'b0;
         chk($sformatf("vec%0d word", i), im_wdata, vecs[i].exp);
         step($sformatf("vec%0d drain", i));
         $display("[TB] vec%0d op=%0d word=%h addr=%h", i, vecs[i].op, vecs[i].exp, m_addr - 32'd4);
      end

      // fill the FIFO with the memory stalled, hold a fifth request, then drain
      im_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         req(5'd0, 5'd1, 5'd2, 5'(k), 5'd0, 26'h0, 32'h00220021 | (k << 11));
         step($sformatf("fill%0d", k));
      end
      chk("full in_ready", {31'b0, in_ready}, 32'd0);
      req(5'd0, 5'd1, 5'd2, 5'd4, 5'd0, 26'h0, 32'h00222021);
      step("held5 a");
      step("held5 b");
      chk("stall wdata", im_wdata, 32'h00220021);
      im_ready = 1'b1;
      step("drain0");
      step("drain1");
      in_valid = 1'b0;
      for (int k = 2; k < 6; k++) step($sformatf("drain%0d", k));
      $display("[TB] full/drain sequence done, addr=%h", im_addr);

      // illegal selector then a legal request
      req(5'd20, 5'd1, 5'd2, 5'd3, 5'd0, 26'h0, 32'h0);
      step("illegal");
      chk("illegal pulse", {31'b0, err_illegal}, 32'd1);
      in_valid = 1'b0;
      step("illegal after");
      chk("illegal pulse end", {31'b0, err_illegal}, 32'd0);
      req(vecs[1].op, vecs[1].rs, vecs[1].rt, vecs[1].rd, vecs[1].sh, vecs[1].imm, vecs[1].exp);
      step("post-illegal accept");
      in_valid = 1'b0;
      step("post-illegal drain");
      $display("[TB] illegal op sequence done, sticky=%0d", err_sticky);

      // clear with two queued words and a simultaneous push
      im_ready = 1'b0;
      req(vecs[0].op, vecs[0].rs, vecs[0].rt, vecs[0].rd, vecs[0].sh, vecs[0].imm, vecs[0].exp);
      step("preclear0");
      req(vecs[2].op, vecs[2].rs, vecs[2].rt, vecs[2].rd, vecs[2].sh, vecs[2].imm, vecs[2].exp);
      step("preclear1");
      req(vecs[4].op, vecs[4].rs, vecs[4].rt, vecs[4].rd, vecs[4].sh, vecs[4].imm, vecs[4].exp);
      clear = 1'b1; im_ready = 1'b1;
      step("clear");
      clear = 1'b0; in_valid = 1'b0;
      chk("clear im_we", {31'b0, im_we}, 32'd0);
      chk("clear im_addr", im_addr, 32'h0000_3000);
      chk("clear word_cnt", {16'b0, word_cnt}, 32'd0);
      chk("clear sticky", {31'b0, err_sticky}, 32'd0);
      step("post-clear");
      $display("[TB] clear sequence done");

      // asynchronous reset between edges while draining
      im_ready = 1'b0;
      req(vecs[5].op, vecs[5].rs, vecs[5].rt, vecs[5].rd, vecs[5].sh, vecs[5].imm, vecs[5].exp);
      step("prerst0");
      req(vecs[6].op, vecs[6].rs, vecs[6].rt, vecs[6].rd, vecs[6].sh, vecs[6].imm, vecs[6].exp);
      step("prerst1");
      in_valid = 1'b0; im_ready = 1'b1;
      step("prerst drain");
      #2 rst = 1'b1;
      #1;
      chk("async im_we", {31'b0, im_we}, 32'd0);
      chk("async im_addr", im_addr, 32'h0000_3000);
      chk("async im_wdata", im_wdata, 32'h0);
      chk("async in_ready", {31'b0, in_ready}, 32'd1);
      mreset();
      @(negedge clk);
      rst = 1'b0;
      check_all("after rst");
      req(vecs[7].op, vecs[7].rs, vecs[7].rt, vecs[7].rd, vecs[7].sh, vecs[7].imm, vecs[7].exp);
      step("post-rst accept");
      in_valid = 1'b0;
      step("post-rst drain");
      $display("[TB] async reset sequence done");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the control decoder: assembles MIPS-32 instruction words from a mnemonic selector plus register and immediate fields.
- Each word is buffered in a small FIFO, then streamed into instruction memory at consecutive word addresses.
- Used by the program loader and by self-checking benches to build programs for the single-cycle core without hand-coded hex.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- AW, 32, width of the instruction-memory byte address.
- BASE_ADDR, 32'h0000_3000, address of the first word written after reset or clear.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- clear  in  1  synchronous: flush FIFO, reload address counter, clear error flag
- in_valid  in  1  encode request valid
- in_ready  out  1  encoder can accept a request; equals !full
- op_sel  in  5  mnemonic selector (see Behaviour)
- rs, rt, rd  in  5 each  register fields
- shamt  in  5  shift amount
- imm26  in  26  immediate; I-type uses [15:0], j uses all 26 bits
- err_illegal  out  1  one-cycle pulse on an accepted illegal op_sel
- err_sticky  out  1  set by any illegal request, cleared by rst or clear
- im_we  out  1  write strobe; equals !empty
- im_ready  in  1  memory accepts the write this cycle
- im_addr  out  AW  byte address of the current word
- im_wdata  out  32  encoded word (FIFO head)
- word_cnt  out  16  words written since reset or clear; saturates at 16'hFFFF

Behaviour:
- op_sel map and encodings (op, funct in hex):
  - 0 addu R/21; 1 add R/20; 2 subu R/23; 3 sub R/22; 4 slt R/2A
  - 5 sll R/00; 6 srl R/02; 7 sra R/03; 8 and R/24
  - 9 ori 0D; 10 sw 2B; 11 lw 23; 12 beq 04; 13 bne 05; 14 lui 0F; 15 slti 0A; 16 j 02
  - 17..31 are illegal.
- Word formats:
  - R-type: {6'h00, rs, rt, rd, shamt, funct}. shamt is forced to 0 for non-shift R-ops. rs is forced to 0 for shifts.
  - I-type: {op, rs, rt, imm26[15:0]}. For lui, rs is forced to 0.
  - j: {6'h02, imm26}.
- Encoding is combinational from the inputs. The word is registered into the FIFO on the accepting edge.
- Accept: rising edge with in_valid && in_ready.
  - Legal op_sel: word pushed.
  - Illegal op_sel: nothing pushed, err_illegal=1 the next cycle, err_sticky set.
  - in_ready is 1 for illegal requests whenever the FIFO is not full.
- Drain: rising edge with im_we && im_ready pops the head. On the same edge im_addr += 4 (wraps modulo 2^AW) and word_cnt increments.
- im_addr and im_wdata hold stable while im_we=1 and im_ready=0.
- Latency: a word accepted at edge N appears on im_wdata with im_we=1 after edge N when the FIFO was empty, i.e. one cycle. Back-to-back throughput is one word per cycle.
- Simultaneous push and pop:
  - Allowed when not full; occupancy is unchanged.
  - When full, in_ready=0 even if a pop occurs that cycle; no bypass.
- Empty: im_we=0 and im_wdata holds its last value. No pop occurs regardless of im_ready.
- clear has priority over push and pop on the same edge. It empties the FIFO, sets im_addr=BASE_ADDR, word_cnt=0, err_sticky=0 and err_illegal=0.
- Reset (async, any time including mid-drain) forces the following; FIFO contents are lost:
  - FIFO empty, in_ready=1, im_we=0
  - im_addr=BASE_ADDR, im_wdata=0, word_cnt=0
  - err_illegal=0, err_sticky=0
- Pointers are log2(DEPTH) bits plus one wrap bit. full = pointers equal except the wrap bit.

Test Plan:
- Reset, then addu rs=1 rt=2 rd=3, im_ready=1 -> next cycle im_we=1, im_wdata=32'h00221821, im_addr=32'h3000. The following cycle im_we=0, im_addr=32'h3004, word_cnt=1.
- Encode set: ori rs=0 rt=1 imm=16'h1234 -> 32'h34011234; lw rs=29 rt=8 imm=16'hFFFC -> 32'h8FA8FFFC; sll rt=2 rd=4 shamt=3 with rs=7 -> 32'h000220C0 (rs forced 0); j imm26=26'h0000C00 -> 32'h08000C00.
- im_ready=0, push 5 legal words with DEPTH=4 -> in_ready drops after the 4th accept and the 5th is held. Then im_ready=1 -> 4 words drain in order at 3000, 3004, 3008, 300C, then the 5th is accepted.
- op_sel=20 with in_valid=1 -> err_illegal pulses for 1 cycle, err_sticky=1, im_we stays 0. A following legal request is still encoded correctly.
- Assert clear with 2 words queued and a push in the same cycle -> FIFO empty, im_addr=32'h3000, word_cnt=0, err_sticky=0, and the pushed word is dropped.
- Assert rst asynchronously mid-drain between clock edges -> im_we=0 and im_addr=32'h3000 immediately, before the next edge.
